// File: rtl/cache_array_assoc_if.sv
// Request / refill bus between the cache controller (master) and the
// set-associative data/tag array (slave).
interface cache_array_assoc_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int WAYS       = 2
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_req;
  logic                  wr_req;
  logic [WIDTH-1:0]      wr_data;
  logic [WIDTH/8-1:0]    wr_be;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  refill_start;
  logic                  fill_valid;
  logic [WIDTH-1:0]      fill_data;
  logic                  busy;
  logic                  refill_done;

  modport master (
    output addr, rd_req, wr_req, wr_data, wr_be, refill_start, fill_valid, fill_data,
    input  hit, hit_way, rd_data, rd_valid, busy, refill_done
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data, wr_be, refill_start, fill_valid, fill_data,
    output hit, hit_way, rd_data, rd_valid, busy, refill_done
  );
endinterface

// File: rtl/cache_array_assoc.sv
// Set-associative data/tag array with byte-enable write hits, a word-serial
// refill sequencer and per-set round-robin replacement.
module cache_array_assoc #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int WORDS      = 4
) (
  input logic                clk,
  input logic                reset,
  cache_array_assoc_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BYTES = WIDTH / 8;
  localparam int DEPTH = SETS * WORDS;
  localparam int MEM_AW = IDX_W + OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state_reg, state_next;

  logic [SETS-1:0][WAYS-1:0]  valid_reg;
  logic [SETS-1:0][WAY_W-1:0] rr_ptr_reg;
  logic [OFF_W-1:0]           beat_cnt_reg;
  logic [IDX_W-1:0]           fill_idx_reg;
  logic [TAG_W-1:0]           fill_tag_reg;
  logic [WAY_W-1:0]           fill_way_reg;
  logic                       victim_reg;
  logic                       refill_done_reg;
  logic                       rd_valid_reg;
  logic                       rd_loaded_reg;
  logic [WAY_W-1:0]           rd_way_reg;

  logic [TAG_W-1:0] tag_in;
  logic [IDX_W-1:0] idx_in;
  logic [OFF_W-1:0] off_in;

  assign tag_in = bus.addr[ADDR_WIDTH-1 -: TAG_W];
  assign idx_in = bus.addr[OFF_W +: IDX_W];
  assign off_in = bus.addr[OFF_W-1:0];

  logic [WAYS-1:0]            way_match;
  logic [WAYS-1:0][TAG_W-1:0] tag_rd;
  logic [WAYS-1:0][WIDTH-1:0] rd_q_all;
  logic [WAYS-1:0]            mem_we;
  logic                       any_match;
  logic [WAY_W-1:0]           match_way;
  logic                       busy;
  logic                       hit;
  logic                       rd_en;
  logic                       wr_en;
  logic                       fill_beat;
  logic                       fill_last;
  logic [WAY_W-1:0]           target_way;
  logic [MEM_AW-1:0]          mem_waddr;
  logic [MEM_AW-1:0]          mem_raddr;
  logic [WIDTH-1:0]           mem_wdata;
  logic [BYTES-1:0]           mem_be;
  logic [WAY_W-1:0]           mem_wway;

  // Scan downward so that, should two ways ever match, the lowest wins.
  always_comb begin
    any_match = 1'b0;
    match_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) begin
        any_match = 1'b1;
        match_way = WAY_W'(w);
      end
    end
  end

  assign busy       = (state_reg == FILL);
  assign hit        = !busy && any_match;
  assign rd_en      = bus.rd_req && !bus.wr_req && hit;
  assign wr_en      = bus.wr_req && hit;
  assign fill_beat  = busy && bus.fill_valid;
  assign fill_last  = fill_beat && (beat_cnt_reg == OFF_W'(WORDS - 1));
  assign target_way = any_match ? match_way : rr_ptr_reg[idx_in];

  // While busy the only array writer is the refill; otherwise write hits.
  assign mem_waddr = busy ? {fill_idx_reg, beat_cnt_reg} : {idx_in, off_in};
  assign mem_raddr = {idx_in, off_in};
  assign mem_wdata = busy ? bus.fill_data : bus.wr_data;
  assign mem_be    = busy ? {BYTES{1'b1}} : bus.wr_be;
  assign mem_wway  = busy ? fill_way_reg : match_way;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.refill_start) state_next = FILL;
      FILL:    if (fill_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      valid_reg       <= '0;
      rr_ptr_reg      <= '0;
      beat_cnt_reg    <= '0;
      fill_idx_reg    <= '0;
      fill_tag_reg    <= '0;
      fill_way_reg    <= '0;
      victim_reg      <= 1'b0;
      refill_done_reg <= 1'b0;
      rd_valid_reg    <= 1'b0;
      rd_loaded_reg   <= 1'b0;
      rd_way_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      refill_done_reg <= fill_last;
      rd_valid_reg    <= rd_en;
      if (rd_en) begin
        rd_loaded_reg <= 1'b1;
        rd_way_reg    <= match_way;
      end
      if (state_reg == IDLE && bus.refill_start) begin
        fill_idx_reg                   <= idx_in;
        fill_tag_reg                   <= tag_in;
        fill_way_reg                   <= target_way;
        victim_reg                     <= !any_match;
        valid_reg[idx_in][target_way]  <= 1'b0;
        beat_cnt_reg                   <= '0;
      end
      if (fill_beat) beat_cnt_reg <= beat_cnt_reg + 1'b1;
      if (fill_last) begin
        valid_reg[fill_idx_reg][fill_way_reg] <= 1'b1;
        // A re-fetch of a resident block keeps its way; only evictions rotate.
        if (victim_reg && WAYS > 1)
          rr_ptr_reg[fill_idx_reg] <= rr_ptr_reg[fill_idx_reg] + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [WIDTH-1:0] data_mem [DEPTH];
      logic [TAG_W-1:0] tag_mem [SETS];
      logic [WIDTH-1:0] rd_q;

      assign mem_we[gi]    = !reset && (fill_beat || wr_en) && (mem_wway == WAY_W'(gi));
      assign tag_rd[gi]    = tag_mem[idx_in];
      assign way_match[gi] = valid_reg[idx_in][gi] && (tag_rd[gi] == tag_in);
      assign rd_q_all[gi]  = rd_q;

      always_ff @(posedge clk) begin
        if (mem_we[gi]) begin
          for (int b = 0; b < BYTES; b++) begin
            if (mem_be[b]) data_mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
          end
        end
        if (rd_en) rd_q <= data_mem[mem_raddr];
      end

      always_ff @(posedge clk) begin
        if (fill_last && !reset && fill_way_reg == WAY_W'(gi))
          tag_mem[fill_idx_reg] <= fill_tag_reg;
      end
    end
  endgenerate

  assign bus.hit         = hit;
  assign bus.hit_way     = hit ? match_way : '0;
  assign bus.rd_data     = rd_loaded_reg ? rd_q_all[rd_way_reg] : '0;
  assign bus.rd_valid    = rd_valid_reg;
  assign bus.busy        = busy;
  assign bus.refill_done = refill_done_reg;
endmodule
